muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: XLEN, 32, operand/result width in bits; legal values are even and >= 4.
REQ-002 Port: clk  in  1  single clock; all state changes on its rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-low reset.
REQ-004 Port: start  in  1  request a new operation; sampled only in IDLE.
REQ-005 Port: kill  in  1  abort the current operation (pipeline flush).
REQ-006 Port: funct3  in  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 Port: a  in  XLEN  rs1 operand (dividend / multiplicand).
REQ-008 Port: b  in  XLEN  rs2 operand (divisor / multiplier).
REQ-009 Port: busy  out  1  high in CALC and DONE.
REQ-010 Port: done  out  1  one-cycle pulse; result is valid in that cycle.
REQ-011 Port: result  out  XLEN  registered result.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-013 In IDLE with start=1 and kill=0, the block SHALL capture funct3, a and b at the clock edge.
REQ-014 After a normal capture, the FSM SHALL enter CALC.
REQ-015 After a special-case capture (REQ-022, REQ-023), the FSM SHALL enter DONE directly.
REQ-016 The block SHALL ignore start outside IDLE; captured operands SHALL not change while busy=1.
REQ-017 CALC SHALL last exactly XLEN cycles; each cycle SHALL perform one radix-2 step.
REQ-018 Multiply steps SHALL be shift-add on operand magnitudes, forming a 2*XLEN product.
REQ-019 Divide steps SHALL be restoring shift-subtract on operand magnitudes.
REQ-020 A down-counter SHALL track the CALC steps; its width SHALL be $clog2(XLEN)+1 bits.
REQ-021 Sign handling SHALL be as follows.
- MUL, MULH, DIV, REM: both operands signed.
- MULHSU: a signed, b unsigned.
- MULHU, DIVU, REMU: both operands unsigned.
- The product or quotient SHALL be negated when the operand signs differ.
- The remainder SHALL take the sign of the dividend.
REQ-022 Divide by zero (b=0) SHALL give: quotient all-ones; remainder = a.
REQ-023 Signed overflow (DIV/REM with a = most-negative and b = all-ones) SHALL give: quotient = a; remainder = 0.
REQ-024 MUL SHALL return the low XLEN bits of the product; MULH/MULHSU/MULHU SHALL return the high XLEN bits.
REQ-025 In DONE, done SHALL be 1 and result SHALL hold the final value; the FSM SHALL then return to IDLE.
REQ-026 Latency, counting the capture edge as cycle 0:
- normal op: done high in cycle XLEN+1;
- special case: done high in cycle 1.
REQ-027 result SHALL hold its value after done until the next DONE or reset.
REQ-028 kill=1 in CALC or DONE SHALL force IDLE at the next edge; done SHALL not assert and result SHALL not update.
REQ-029 kill=1 with start=1 in IDLE: kill SHALL win and nothing SHALL be captured.
REQ-030 done and busy SHALL be decoded from the state register only, with no combinational path from inputs.

Reset
REQ-031 reset low SHALL immediately (asynchronously) force the following:
- state to IDLE;
- busy, done and result to 0;
- counter and internal accumulators to 0.
REQ-032 Reset mid-CALC SHALL discard the operation; after release, the first start SHALL behave as from power-up.

Structure
REQ-033 A shared package muldiv_pkg SHALL hold:
- the funct3 op-code enum;
- the FSM state enum;
- the M-extension opcode/funct7 constants for decoder use.
REQ-034 No sub-module is required; the block SHALL be a single module.
REQ-035 The FSM and the datapath registers SHALL be separate always_ff processes.

Verification (XLEN=32, start in cycle 0)
REQ-036 MUL a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB, done in cycle 33 only, busy high in cycles 1-33.
REQ-037 High-half multiplies:
- MULH 0x80000000 x 0x80000000 -> 0x40000000;
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE;
- MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-038 Signed divide: DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF.
REQ-039 Special cases, each with done in cycle 1:
- DIVU 5/0 -> 0xFFFFFFFF;
- REMU 5/0 -> 5;
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000;
- REM same operands -> 0.
REQ-040 Abort and ignored start:
- kill in cycle 10 of a DIVU -> no done, busy low from cycle 11;
- a start in cycle 11 SHALL be accepted and complete correctly;
- a start applied in cycle 5 of a running op SHALL be ignored.
REQ-041 reset driven low in cycle 20 of a MUL -> busy, done and result read 0 before the next edge; no done after release.

Source files
------------

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op-codes, FSM states and decoder constants for muldiv_unit
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } muldiv_state_e;

  // Decoder-side match values for the RV32M instruction group.
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

endpackage

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative radix-2 RV32M multiply/divide unit
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  muldiv_state_e   state_q, state_d;
  muldiv_op_e      op_q;
  logic            neg_q, rem_neg_q;
  logic [XLEN-1:0] opnd_q;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0] result_q;

  muldiv_op_e      op_in;
  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] special_res;
  logic            capture, step, last_step;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift, div_diff;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, fin_res;

  // Operand decode: sign selection, magnitudes and the two short-circuit cases.
  always_comb begin
    op_in    = muldiv_op_e'(funct3);
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (op_in)
      OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      OP_MULHSU: a_signed = 1'b1;
      default: ;
    endcase
    a_neg    = a_signed & a[XLEN-1];
    b_neg    = b_signed & b[XLEN-1];
    a_mag    = a_neg ? -a : a;
    b_mag    = b_neg ? -b : b;
    div_zero = funct3[2] && (b == '0);
    div_ovf  = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
               (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    special  = div_zero | div_ovf;
    if (div_zero) special_res = funct3[1] ? a : '1;
    else          special_res = funct3[1] ? '0 : a;
  end

  assign capture   = (state_q == S_IDLE) && start && !kill;
  assign step      = (state_q == S_CALC) && !kill;
  assign last_step = (cnt_q == CNT_W'(1));

  // One radix-2 step: shift-add for multiply, restoring shift-subtract for divide.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = acc_q[2*XLEN-1:XLEN-1];
    div_diff  = div_shift - {1'b0, opnd_q};
    if (op_q[2]) begin
      if (!div_diff[XLEN]) acc_d = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      else                 acc_d = {acc_q[2*XLEN-2:0], 1'b0};
    end else begin
      acc_d = {mul_sum, acc_q[XLEN-1:1]};
    end
    prod = neg_q ? -acc_d : acc_d;
    quo  = acc_d[XLEN-1:0];
    rem  = acc_d[2*XLEN-1:XLEN];
    case (op_q)
      OP_MUL:                      fin_res = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fin_res = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             fin_res = neg_q ? -quo : quo;
      default:                     fin_res = rem_neg_q ? -rem : rem;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (capture) state_d = special ? S_DONE : S_CALC;
      S_CALC: begin
        if (kill)           state_d = S_IDLE;
        else if (last_step) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Multiply: acc = {partial, multiplier}. Divide: acc = {remainder, quotient/dividend}.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q      <= OP_MUL;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      opnd_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
    end else if (capture) begin
      op_q      <= op_in;
      neg_q     <= a_neg ^ b_neg;
      rem_neg_q <= a_neg;
      opnd_q    <= funct3[2] ? b_mag : a_mag;
      acc_q     <= {{XLEN{1'b0}}, (funct3[2] ? a_mag : b_mag)};
      cnt_q     <= special ? '0 : CNT_W'(XLEN);
      if (special) result_q <= special_res;
    end else if (step) begin
      acc_q <= acc_d;
      cnt_q <= cnt_q - CNT_W'(1);
      if (last_step) result_q <= fin_res;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .kill(kill), .funct3(funct3),
    .a(a), .b(b), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge (cycle 0); returns just after the capture edge.
  task automatic launch(input logic [2:0] f, input logic [31:0] av, input logic [31:0] bv);
    funct3 = f; a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; funct3 = 3'b011; a = 32'hDEADBEEF; b = 32'h0BADF00D;
  endtask

  task automatic wait_done(input string tag, input int exp_cyc, input logic [31:0] exp_res,
                           input int ign_cyc);
    int first = 0;
    int ndone = 0;
    logic busy_ok = 1'b1;
    logic [31:0] res_at_done = '0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (first == 0) first = n;
        res_at_done = result;
      end
      if (busy !== (n <= exp_cyc)) busy_ok = 1'b0;
      start = (n == ign_cyc);
    end
    start = 1'b0;
    check({tag, " done_cycle"}, 64'(first), 64'(exp_cyc));
    check({tag, " done_count"}, 64'(ndone), 64'd1);
    check({tag, " busy_window"}, 64'(busy_ok), 64'd1);
    check({tag, " result"}, 64'(res_at_done), 64'(exp_res));
    check({tag, " result_held"}, 64'(result), 64'(exp_res));
  endtask

  task automatic run(input string tag, input logic [2:0] f, input logic [31:0] av,
                     input logic [31:0] bv, input int exp_cyc, input logic [31:0] exp_res);
    launch(f, av, bv);
    wait_done(tag, exp_cyc, exp_res, 0);
  endtask

  initial begin
    int ndone;
    #1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset result", 64'(result), 64'd0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);

    run("MUL", 3'b000, 32'd7, 32'hFFFFFFFD, 33, 32'hFFFFFFEB);
    run("MULH", 3'b001, 32'h80000000, 32'h80000000, 33, 32'h40000000);
    run("MULHU", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'hFFFFFFFE);
    run("MULHSU", 3'b010, 32'hFFFFFFFF, 32'd2, 33, 32'hFFFFFFFF);
    run("DIV", 3'b100, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFD);
    run("REM", 3'b110, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFF);
    run("DIVU0", 3'b101, 32'd5, 32'd0, 1, 32'hFFFFFFFF);
    run("REMU0", 3'b111, 32'd5, 32'd0, 1, 32'd5);
    run("DIVOVF", 3'b100, 32'h80000000, 32'hFFFFFFFF, 1, 32'h80000000);
    run("REMOVF", 3'b110, 32'h80000000, 32'hFFFFFFFF, 1, 32'd0);
    run("MULBIG", 3'b000, 32'h12345678, 32'h00000010, 33, 32'h23456780);

    // Start in cycle 5 must be ignored; the running op still finishes unchanged.
    launch(3'b101, 32'd1000, 32'd7);
    wait_done("IGNSTART", 33, 32'd142, 5);

    // Kill in cycle 10: no done, result keeps previous value, restart in cycle 11.
    launch(3'b101, 32'd100, 32'd7);
    ndone = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    kill = 1'b1;
    @(posedge clk); #1; kill = 1'b0;
    @(negedge clk);
    check("KILL busy_c11", 64'(busy), 64'd0);
    check("KILL done_count", 64'(ndone + int'(done)), 64'd0);
    check("KILL result_kept", 64'(result), 64'd142);
    launch(3'b101, 32'd100, 32'd7);
    wait_done("RESTART", 33, 32'd14, 0);

    // Kill together with start in IDLE: nothing captured.
    kill = 1'b1; funct3 = 3'b000; a = 32'd3; b = 32'd3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; kill = 1'b0;
    @(negedge clk);
    check("KILLSTART busy", 64'(busy), 64'd0);

    // Asynchronous reset in cycle 20 of a MUL.
    launch(3'b000, 32'd9, 32'd9);
    for (int n = 1; n <= 20; n++) @(negedge clk);
    reset = 1'b0;
    #1;
    check("RST busy", 64'(busy), 64'd0);
    check("RST done", 64'(done), 64'd0);
    check("RST result", 64'(result), 64'd0);
    @(negedge clk); @(negedge clk); reset = 1'b1;
    ndone = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("RST no_done", 64'(ndone), 64'd0);
    run("POSTRST", 3'b000, 32'd9, 32'd9, 33, 32'd81);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
